// File: rtl/t03_nibble_tx.sv
// Snapshots nine upstream nibbles on start and streams them over a 4-bit valid/ready bus.
// Optional parity nibble when T03_NIBBLE_PARITY_EN is defined.
module t03_nibble_tx #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] x1_out1,
    input  logic [3:0] x1_out2,
    input  logic [3:0] y1_out1,
    input  logic [3:0] y1_out2,
    input  logic [3:0] x2_out1,
    input  logic [3:0] x2_out2,
    input  logic [3:0] y2_out1,
    input  logic [3:0] y2_out2,
    input  logic [3:0] player_state_out,
    input  logic       nib_ready,
    output logic [3:0] nib_data,
    output logic       nib_valid,
    output logic       nib_last,
    output logic       busy,
    output logic       done
);

`ifdef T03_NIBBLE_PARITY_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t     r_state;
    logic [3:0] r_index;
    logic [3:0] r_gap_cnt;
    logic [3:0] r_shadow [9];
    logic [3:0] r_nib_data;
    logic       r_nib_valid;
    logic       r_nib_last;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_next_idx;
    logic [3:0] w_next_data;
    logic       w_xfer;

    assign w_next_idx = r_index + 4'd1;
    assign w_xfer     = r_nib_valid & nib_ready;

`ifdef T03_NIBBLE_PARITY_EN
    logic [3:0] w_parity;

    always_comb begin
        w_parity = 4'd0;
        for (int i = 0; i < 9; i++) begin
            w_parity = w_parity ^ r_shadow[i];
        end
    end
`endif

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next_data = 4'd0;
        case (w_next_idx)
            4'd1:    w_next_data = r_shadow[1];
            4'd2:    w_next_data = r_shadow[2];
            4'd3:    w_next_data = r_shadow[3];
            4'd4:    w_next_data = r_shadow[4];
            4'd5:    w_next_data = r_shadow[5];
            4'd6:    w_next_data = r_shadow[6];
            4'd7:    w_next_data = r_shadow[7];
            4'd8:    w_next_data = r_shadow[8];
`ifdef T03_NIBBLE_PARITY_EN
            4'd9:    w_next_data = w_parity;
`endif
            default: w_next_data = 4'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_index     <= 4'd0;
            r_gap_cnt   <= 4'd0;
            // NOTE: the shadow file is small and must read as zero after reset, so it is reset explicitly.
            for (int i = 0; i < 9; i++) begin
                r_shadow[i] <= 4'd0;
            end
            r_nib_data  <= 4'd0;
            r_nib_valid <= 1'b0;
            r_nib_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shadow[0] <= x1_out1;
                        r_shadow[1] <= x1_out2;
                        r_shadow[2] <= y1_out1;
                        r_shadow[3] <= y1_out2;
                        r_shadow[4] <= x2_out1;
                        r_shadow[5] <= x2_out2;
                        r_shadow[6] <= y2_out1;
                        r_shadow[7] <= y2_out2;
                        r_shadow[8] <= player_state_out;
                        r_index     <= 4'd0;
                        r_nib_data  <= x1_out1;
                        r_nib_valid <= 1'b1;
                        r_nib_last  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_index == LAST_IDX) begin
                            r_nib_valid <= 1'b0;
                            r_nib_last  <= 1'b0;
                            r_nib_data  <= 4'd0;
                            r_done      <= 1'b1;
                            if (GAP_CYCLES > 0) begin
                                r_gap_cnt <= 4'd0;
                                r_state   <= S_GAP;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_index    <= w_next_idx;
                            r_nib_data <= w_next_data;
                            r_nib_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= 4'd0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign nib_data  = r_nib_data;
    assign nib_valid = r_nib_valid;
    assign nib_last  = r_nib_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_t03_nibble_tx.sv
// Self-checking bench for t03_nibble_tx: directed test-plan steps plus randomized frames
// scored against a snapshot-and-stream reference model.
module tb_t03_nibble_tx;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] in_nib [9];
    logic       nib_ready;
    logic [3:0] nib_data;
    logic       nib_valid;
    logic       nib_last;
    logic       busy;
    logic       done;

    int         n_vectors = 0;
    int         n_miscompares = 0;
    logic [3:0] exp_q [$];
    int         exp_len = 0;

    t03_nibble_tx #(.GAP_CYCLES(GAP)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .x1_out1          (in_nib[0]),
        .x1_out2          (in_nib[1]),
        .y1_out1          (in_nib[2]),
        .y1_out2          (in_nib[3]),
        .x2_out1          (in_nib[4]),
        .x2_out2          (in_nib[5]),
        .y2_out1          (in_nib[6]),
        .y2_out2          (in_nib[7]),
        .player_state_out (in_nib[8]),
        .nib_ready        (nib_ready),
        .nib_data         (nib_data),
        .nib_valid        (nib_valid),
        .nib_last         (nib_last),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic eb, input logic ed,
                             input logic [3:0] edata, input logic el);
        check({tag, "_valid"}, 32'(nib_valid), 32'(ev));
        check({tag, "_busy"},  32'(busy),      32'(eb));
        check({tag, "_done"},  32'(done),      32'(ed));
        check({tag, "_data"},  32'(nib_data),  32'(edata));
        check({tag, "_last"},  32'(nib_last),  32'(el));
    endtask

    // Reference model: a frame is the nine input nibbles in port order, plus their XOR when parity is built in.
    task automatic build_expected();
        logic [3:0] par;
        par = 4'd0;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(in_nib[i]);
            par = par ^ in_nib[i];
        end
`ifdef T03_NIBBLE_PARITY_EN
        exp_q.push_back(par);
`endif
        exp_len = exp_q.size();
    endtask

    task automatic set_inputs_seq();
        for (int i = 0; i < 9; i++) in_nib[i] = 4'(i + 1);
    endtask

    task automatic set_inputs_rand();
        for (int i = 0; i < 9; i++) in_nib[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic do_start();
        build_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Consumes one frame; ends on the cycle where done should be high.
    task automatic recv_frame(input string tag, input logic [31:0] stall_mask,
                              input int poke_cycle, output int send_cycles);
        int idx;
        idx = 0;
        send_cycles = 0;
        while (idx < exp_len) begin
            if (send_cycles >= 64) begin
                n_vectors++;
                n_miscompares++;
                $error("FAIL %s_timeout: observed %0d transfers expected %0d", tag, idx, exp_len);
                break;
            end
            check_out(tag, 1'b1, 1'b1, 1'b0, exp_q[idx], idx == exp_len - 1);
            nib_ready = (send_cycles < 32) ? !stall_mask[send_cycles] : 1'b1;
            if (poke_cycle >= 0 && send_cycles == poke_cycle) begin
                for (int i = 0; i < 9; i++) in_nib[i] = 4'hF;
                start = 1'b1;
            end else if (poke_cycle >= 0 && send_cycles == poke_cycle + 1) begin
                start = 1'b0;
            end
            if (nib_ready) idx++;
            send_cycles++;
            tick();
        end
        nib_ready = 1'b1;
        check({tag, "_done_pulse"}, 32'(done),      32'd1);
        check({tag, "_done_valid"}, 32'(nib_valid), 32'd0);
        check({tag, "_done_last"},  32'(nib_last),  32'd0);
    endtask

    task automatic gap_idle(input string tag);
        for (int i = 0; i < GAP; i++) begin
            check({tag, "_gap_busy"},  32'(busy),      32'd1);
            check({tag, "_gap_valid"}, 32'(nib_valid), 32'd0);
            tick();
        end
        check({tag, "_idle_busy"},  32'(busy),      32'd0);
        check({tag, "_idle_valid"}, 32'(nib_valid), 32'd0);
        check({tag, "_idle_done"},  32'(done),      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        int cnt;
        logic [31:0] mask;

        rst = 1'b1;
        start = 1'b0;
        nib_ready = 1'b1;
        set_inputs_rand();

        // Reset then idle
        tick();
        check_out("rst1", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        check_out("rst2", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end

        // Nominal frame 1..9
        set_inputs_seq();
        do_start();
        recv_frame("nominal", 32'd0, -1, sc);
        check("nominal_cycles", 32'(sc), 32'(exp_len));
        gap_idle("nominal");

        // Backpressure on SEND cycles 3..5
        set_inputs_seq();
        do_start();
        recv_frame("stall", 32'h0000_001C, -1, sc);
        check("stall_cycles", 32'(sc), 32'(exp_len + 3));
        gap_idle("stall");

        // Snapshot and ignored start: inputs go to 0xF and start pulses mid-frame
        set_inputs_seq();
        do_start();
        recv_frame("snap", 32'd0, 3, sc);
        gap_idle("snap");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("snap_noframe", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        do_start();
        recv_frame("snap_f", 32'd0, -1, sc);
        gap_idle("snap_f");

        // Mid-frame reset after four transfers
        set_inputs_rand();
        do_start();
        for (int i = 0; i < 4; i++) begin
            check_out("abort_pre", 1'b1, 1'b1, 1'b0, exp_q[i], 1'b0);
            nib_ready = 1'b1;
            tick();
        end
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_out("abort_rst", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("abort_quiet", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        set_inputs_rand();
        do_start();
        recv_frame("abort_new", 32'd0, -1, sc);
        gap_idle("abort_new");

        // Back-to-back frames with start held high
        set_inputs_rand();
        build_expected();
        start = 1'b1;
        tick();
        recv_frame("b2b_a", 32'd0, -1, sc);
        cnt = 0;
        while (!nib_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("b2b_restart_gap", 32'(cnt), 32'(GAP + 1));
        start = 1'b0;
        recv_frame("b2b_b", 32'd0, -1, sc);
        gap_idle("b2b_b");

        // Randomized frames with random backpressure
        for (int f = 0; f < 16; f++) begin
            set_inputs_rand();
            mask = $urandom() & $urandom();
            do_start();
            recv_frame("rand", mask, -1, sc);
            gap_idle("rand");
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/t03_nibble_tx.md
# t03_nibble_tx

Downstream consumer of the DPU-to-MUX nibble register stage. Snapshots the nine 4-bit nibbles that stage holds (two per coordinate, plus player state) on a start request, then streams them one per transfer over a 4-bit valid/ready bus toward the off-block display link. A frame-done pulse is issued after the final nibble, and an optional gap is inserted before the next frame is accepted.

## Interface
Parameters:
- GAP_CYCLES, default 2: idle cycles enforced after a frame completes before `start` is accepted again; range 0–15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  frame request; sampled only in IDLE.
- x1_out1, x1_out2, y1_out1, y1_out2, x2_out1, x2_out2, y2_out1, y2_out2  input  4 each  coordinate nibbles from the upstream stage (out1 = low nibble, out2 = high nibble).
- player_state_out  input  4  player-state nibble from the upstream stage.
- nib_ready  input  1  downstream accepts the current nibble.
- nib_data  output  4  current nibble.
- nib_valid  output  1  `nib_data` is valid.
- nib_last  output  1  current nibble is the last of the frame.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - On `start`=1, all nine inputs are captured into shadow registers, the index is set to 0, and the FSM moves to SEND.
  - Inputs are not sampled at any other time.
- SEND:
  - `nib_valid`=1 and `nib_data`=shadow[index].
  - Transmission order for index 0..8: x1_out1, x1_out2, y1_out1, y1_out2, x2_out1, x2_out2, y2_out1, y2_out2, player_state_out.
  - A transfer occurs when `nib_valid && nib_ready`; the index then increments.
  - When `nib_ready`=0, `nib_data`, `nib_last` and the index hold.
  - `nib_last`=1 exactly while the final index is presented.
  - On the final transfer, `done` pulses on the next cycle. The FSM moves to GAP if GAP_CYCLES>0, otherwise to IDLE.
- GAP:
  - Counts GAP_CYCLES cycles, then moves to IDLE.
  - `nib_valid`=0.
- `start` asserted outside IDLE is ignored; it is neither queued nor latched.
- Upstream inputs changing mid-frame have no effect, because the shadow copy is used.
- The index is 4 bits wide. It resets to 0 at each frame start and never wraps within a frame.

## Timing
- Reset values: `nib_data`=0, `nib_valid`=0, `nib_last`=0, `busy`=0, `done`=0. State=IDLE, index=0, shadow=0, gap counter=0.
- All outputs are registered.
- `start` high at edge k gives `nib_valid`=1 and `busy`=1 from cycle k+1.
- With `nib_ready` held high, the frame takes 9 consecutive transfer cycles (10 with parity). `done` is high the cycle after the last transfer, and `nib_valid`=0 in that same cycle.
- Back-to-back frames with `start` held high: the next `nib_valid` rises GAP_CYCLES+1 cycles after `done`.
- Reset asserted mid-frame aborts the frame: outputs take their reset values on the next edge and no `done` is issued.
- Reset has priority over `start`.

## Configuration
- Macro: `T03_NIBBLE_PARITY_EN`.
- Defined: a 10th nibble (index 9) is appended, equal to the XOR of the nine shadow nibbles. `nib_last` moves to that nibble.
- Undefined: frames are 9 nibbles and no parity logic is present.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then `start`=0 for 10 cycles.
  - Required: all outputs stay 0.
- Nominal frame:
  - Stimulus: inputs x1_out1..player_state_out = 1,2,...,9, `nib_ready`=1, `start` pulsed.
  - Required: `nib_data` sequence 1..9 on consecutive cycles, `nib_last` high only with 9, `done` one cycle later, `busy` low after GAP_CYCLES=2.
- Backpressure:
  - Stimulus: same frame, `nib_ready` low on cycles 3–5 of SEND.
  - Required: `nib_data`=3 held stable throughout the stall, no nibble dropped or duplicated, 12 SEND cycles total.
- Snapshot and ignored start:
  - Stimulus: change all inputs to 0xF and pulse `start` during SEND.
  - Required: the frame still carries 1..9, and no second frame begins until `start` is reasserted in IDLE.
- Mid-frame reset:
  - Stimulus: `rst` asserted after 4 transfers.
  - Required: `nib_valid`=0 and `busy`=0 next cycle, `done` never pulses, and a new `start` sends from index 0.
- Parity build:
  - Stimulus: `T03_NIBBLE_PARITY_EN` defined, inputs 1..9.
  - Required: 10th nibble = 0x1 (XOR of 1..9), with `nib_last` on it.
